// File: rtl/decode_stage_pkg.sv
// Shared definitions for the decode stage: ALU op codes, instruction field positions, register file geometry.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package decode_stage_pkg;

    localparam int INSTR_W    = 32;
    localparam int OP_W       = 5;
    localparam int REG_ADDR_W = 4;
    localparam int NREG_DEF   = 16;
    localparam int IMM_W      = 16;

    // Instruction field positions
    localparam int OP_HI   = 31;
    localparam int OP_LO   = 27;
    localparam int RD_HI   = 26;
    localparam int RD_LO   = 23;
    localparam int RS1_HI  = 22;
    localparam int RS1_LO  = 19;
    localparam int UIMM_B  = 18;
    localparam int RS2_HI  = 17;
    localparam int RS2_LO  = 14;
    localparam int IMM_HI  = 15;
    localparam int IMM_LO  = 0;

    typedef enum logic [OP_W-1:0] {
        ALUOP_MOV  = 5'h00,
        ALUOP_MOVL = 5'h02,
        ALUOP_MOVH = 5'h03,
        ALUOP_ADD  = 5'h04,
        ALUOP_SUB  = 5'h05,
        ALUOP_MUL  = 5'h06,
        ALUOP_DIV  = 5'h07,
        ALUOP_AND  = 5'h08,
        ALUOP_OR   = 5'h09,
        ALUOP_NOT  = 5'h0A,
        ALUOP_XOR  = 5'h0B,
        ALUOP_SHL  = 5'h0C,
        ALUOP_SHR  = 5'h0D,
        ALUOP_ASR  = 5'h0E
    } aluop_e;

    // Raw instruction fields; rs2 and imm overlap in the encoding, use_imm selects which one matters.
    typedef struct packed {
        logic [OP_W-1:0]       op;
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_ADDR_W-1:0] rs1;
        logic                  use_imm;
        logic [REG_ADDR_W-1:0] rs2;
        logic [IMM_W-1:0]      imm;
    } dec_fields_t;

    function automatic dec_fields_t f_split(input logic [INSTR_W-1:0] instr);
        dec_fields_t f;
        f.op      = instr[OP_HI:OP_LO];
        f.rd      = instr[RD_HI:RD_LO];
        f.rs1     = instr[RS1_HI:RS1_LO];
        f.use_imm = instr[UIMM_B];
        f.rs2     = instr[RS2_HI:RS2_LO];
        f.imm     = instr[IMM_HI:IMM_LO];
        return f;
    endfunction

    function automatic logic f_is_legal(input logic [OP_W-1:0] op);
        case (op)
            ALUOP_MOV, ALUOP_MOVL, ALUOP_MOVH, ALUOP_ADD, ALUOP_SUB,
            ALUOP_MUL, ALUOP_DIV, ALUOP_AND, ALUOP_OR, ALUOP_NOT,
            ALUOP_XOR, ALUOP_SHL, ALUOP_SHR, ALUOP_ASR: return 1'b1;
            default:                                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_regfile_bypass.sv
// Register file, 2 read / 1 write ports, R0 hard-wired to zero, same-cycle write-through to both read ports.
// Latency: reads combinational; write visible to the array on the next clock edge, to the read ports immediately.
// Backpressure: none; writes are always accepted.
module regfile_bypass #(
    parameter int DATA_W = 32,
    parameter int NREG   = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr_a,
    input  logic [ADDR_W-1:0] i_raddr_b,
    output logic [DATA_W-1:0] o_rdata_a,
    output logic [DATA_W-1:0] o_rdata_b
);

    logic [DATA_W-1:0] r_regs [NREG];
    logic [DATA_W-1:0] w_rdata_a;
    logic [DATA_W-1:0] w_rdata_b;

    // Array write; R0 is never written so it always reads back as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
        end else if (i_we && (i_waddr != '0)) begin
            r_regs[i_waddr] <= i_wdata;
        end
    end

    // Read ports with write-through bypass so a dependant can issue in the writeback cycle.
    always_comb begin
        w_rdata_a = '0;
        w_rdata_b = '0;
        if (i_raddr_a != '0) begin
            w_rdata_a = (i_we && (i_waddr == i_raddr_a)) ? i_wdata : r_regs[i_raddr_a];
        end
        if (i_raddr_b != '0) begin
            w_rdata_b = (i_we && (i_waddr == i_raddr_b)) ? i_wdata : r_regs[i_raddr_b];
        end
    end

    assign o_rdata_a = w_rdata_a;
    assign o_rdata_b = w_rdata_b;

endmodule

// File: rtl/decode_stage.sv
// ID stage: decodes an instruction, reads operands (with writeback bypass) and tracks pending destinations.
// Latency: 1 cycle from an accepted instruction to out_valid.
// Backpressure: in_ready drops on a busy source or a full, unconsumed output register; outputs hold while out_ready is low.
module decode_stage
    import decode_stage_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int NREG   = NREG_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INSTR_W-1:0]    in_instr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OP_W-1:0]       aluop,
    output logic                  is_alu_op,
    output logic [DATA_W-1:0]     val1,
    output logic [DATA_W-1:0]     val2,
    output logic [REG_ADDR_W-1:0] rd,
    output logic                  illegal,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data
);

    dec_fields_t           w_f;
    logic                  w_legal;
    logic                  w_movlh;
    logic                  w_use_imm16;
    logic                  w_rs2_used;
    logic [REG_ADDR_W-1:0] w_src_a;
    logic [DATA_W-1:0]     w_rdata_a;
    logic [DATA_W-1:0]     w_rdata_b;
    logic [DATA_W-1:0]     w_imm_ext;
    logic                  w_busy_a;
    logic                  w_busy_b;
    logic                  w_stall;
    logic                  w_issue;
    logic [NREG-1:0]       r_busy;
    logic [NREG-1:0]       w_busy_nxt;

    logic                  r_out_valid;
    logic [OP_W-1:0]       r_aluop;
    logic                  r_is_alu_op;
    logic [DATA_W-1:0]     r_val1;
    logic [DATA_W-1:0]     r_val2;
    logic [REG_ADDR_W-1:0] r_rd;
    logic                  r_illegal;

    assign w_f     = f_split(in_instr);
    assign w_legal = f_is_legal(w_f.op);
    assign w_movlh = (w_f.op == ALUOP_MOVL) || (w_f.op == ALUOP_MOVH);

    // MOVL/MOVH always carry imm16 and read the destination as the half to be preserved.
    assign w_use_imm16 = w_f.use_imm || w_movlh;
    assign w_rs2_used  = !w_use_imm16;
    assign w_src_a     = w_movlh ? w_f.rd : w_f.rs1;
    assign w_imm_ext   = {{(DATA_W-IMM_W){1'b0}}, w_f.imm};

    regfile_bypass #(
        .DATA_W (DATA_W),
        .NREG   (NREG),
        .ADDR_W (REG_ADDR_W)
    ) u_rf (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_we      (wb_en),
        .i_waddr   (wb_addr),
        .i_wdata   (wb_data),
        .i_raddr_a (w_src_a),
        .i_raddr_b (w_f.rs2),
        .o_rdata_a (w_rdata_a),
        .o_rdata_b (w_rdata_b)
    );

    // A source being written back this cycle is not a hazard: the bypass delivers its value.
    assign w_busy_a = r_busy[w_src_a] && !(wb_en && (wb_addr == w_src_a));
    assign w_busy_b = r_busy[w_f.rs2] && !(wb_en && (wb_addr == w_f.rs2));
    assign w_stall  = w_busy_a || (w_rs2_used && w_busy_b);

    assign in_ready = !w_stall && (!r_out_valid || out_ready);
    assign w_issue  = in_valid && in_ready;

    // Scoreboard update: writeback clears, then a legal issue sets (set wins on the same register).
    always_comb begin
        w_busy_nxt = r_busy;
        if (wb_en) begin
            w_busy_nxt[wb_addr] = 1'b0;
        end
        if (w_issue && w_legal && (w_f.rd != '0)) begin
            w_busy_nxt[w_f.rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busy_nxt;
        end
    end

    // Output pipeline register: load on issue, empty when consumed with nothing new, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_aluop     <= '0;
            r_is_alu_op <= 1'b0;
            r_val1      <= '0;
            r_val2      <= '0;
            r_rd        <= '0;
            r_illegal   <= 1'b0;
        end else if (w_issue) begin
            r_out_valid <= 1'b1;
            r_aluop     <= w_f.op;
            r_is_alu_op <= w_legal;
            r_val1      <= w_rdata_a;
            r_val2      <= w_use_imm16 ? w_imm_ext : w_rdata_b;
            r_rd        <= w_legal ? w_f.rd : '0;
            r_illegal   <= !w_legal;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign aluop     = r_aluop;
    assign is_alu_op = r_is_alu_op;
    assign val1      = r_val1;
    assign val2      = r_val2;
    assign rd        = r_rd;
    assign illegal   = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed hazard/backpressure/reset sequences followed by random traffic.
// Expected outputs come from a register/busy-bit reference model and are queued at issue time.
// A separate monitor compares every presented output against the queue head.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  aluop;
    logic        is_alu_op;
    logic [31:0] val1;
    logic [31:0] val2;
    logic [3:0]  rd;
    logic        illegal;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;

    decode_stage #(.DATA_W(32), .NREG(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .aluop     (aluop),
        .is_alu_op (is_alu_op),
        .val1      (val1),
        .val2      (val2),
        .rd        (rd),
        .illegal   (illegal),
        .wb_en     (wb_en),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  aluop;
        logic        is_alu;
        logic        ill;
        logic [3:0]  rd;
        logic [31:0] v1;
        logic [31:0] v2;
    } exp_t;

    exp_t        q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_regs [16];
    logic        m_busy [16];
    logic        m_out_valid;
    logic [31:0] legal_mask = 32'h0000_7FFD;
    logic [4:0]  legal_ops [14];

    function automatic logic [31:0] m_read(input logic [3:0] a, input logic we,
                                           input logic [3:0] wa, input logic [31:0] wd);
        if (a == 4'd0) return 32'd0;
        if (we && (wa == a)) return wd;
        return m_regs[a];
    endfunction

    function automatic logic [31:0] mk(input logic [4:0] op, input logic [3:0] rdv,
                                       input logic [3:0] rs1, input logic ui,
                                       input logic [3:0] rs2, input logic [15:0] imm);
        logic [31:0] w;
        w = {op, rdv, rs1, ui, 18'd0};
        if (ui) w[15:0] = imm;
        else    w[17:14] = rs2;
        return w;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 16; i++) begin
            m_regs[i] = 32'd0;
            m_busy[i] = 1'b0;
        end
        m_out_valid = 1'b0;
        q.delete();
    endtask

    // One clock of stimulus; the model predicts acceptance and queues the expected output.
    task automatic cyc(input logic v, input logic [31:0] ins, input logic ordy,
                       input logic we, input logic [3:0] wa, input logic [31:0] wd,
                       output logic issued);
        logic [4:0]  op;
        logic [3:0]  f_rd, f_rs1, f_rs2, src1;
        logic        f_ui, legal, movlh, stall, exp_rdy;
        logic [15:0] f_imm;
        exp_t        e;
        @(negedge clk);
        in_valid = v; in_instr = ins; out_ready = ordy;
        wb_en = we; wb_addr = wa; wb_data = wd;
        #1;
        op    = ins[31:27];
        f_rd  = ins[26:23];
        f_rs1 = ins[22:19];
        f_ui  = ins[18];
        f_rs2 = ins[17:14];
        f_imm = ins[15:0];
        legal = legal_mask[op];
        movlh = (op == 5'd2) || (op == 5'd3);
        src1  = movlh ? f_rd : f_rs1;
        stall = 1'b0;
        if (m_busy[src1] && !(we && wa == src1)) stall = 1'b1;
        if (!movlh && !f_ui && m_busy[f_rs2] && !(we && wa == f_rs2)) stall = 1'b1;
        exp_rdy = !stall && (!m_out_valid || ordy);
        checks++;
        if (out_valid !== m_out_valid) begin
            errors++;
            $display("FAIL out_valid: got %b expected %b at %0t", out_valid, m_out_valid, $time);
        end
        if (v) begin
            checks++;
            if (in_ready !== exp_rdy) begin
                errors++;
                $display("FAIL in_ready: got %b expected %b instr=%h at %0t", in_ready, exp_rdy, ins, $time);
            end
        end
        issued = v && exp_rdy;
        e.aluop  = op;
        e.is_alu = legal;
        e.ill    = !legal;
        e.rd     = legal ? f_rd : 4'd0;
        e.v1     = m_read(src1, we, wa, wd);
        e.v2     = (f_ui || movlh) ? {16'd0, f_imm} : m_read(f_rs2, we, wa, wd);
        @(posedge clk);
        if (we && wa != 4'd0) m_regs[wa] = wd;
        if (we) m_busy[wa] = 1'b0;
        if (issued && legal && f_rd != 4'd0) m_busy[f_rd] = 1'b1;
        if (issued) begin
            m_out_valid = 1'b1;
            q.push_back(e);
        end else if (ordy) begin
            m_out_valid = 1'b0;
        end
    endtask

    // Monitor: every presented output must match the queue head; pop on transfer.
    initial begin
        exp_t act;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n === 1'b1 && out_valid === 1'b1) begin
                checks++;
                act = {aluop, is_alu_op, illegal, rd, val1, val2};
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: got %h with nothing expected at %0t", act, $time);
                end else begin
                    if (act !== q[0]) begin
                        errors++;
                        $display("FAIL output: got %h expected %h at %0t", act, q[0], $time);
                    end
                    if (out_ready === 1'b1) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic        iss;
        logic        have;
        logic [31:0] ins;
        logic [31:0] a_op, b_op, c_op;
        logic [4:0]  op;
        logic [79:0] outs;

        legal_ops = '{5'd0, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
                      5'd8, 5'd9, 5'd10, 5'd11, 5'd12, 5'd13, 5'd14};
        rst_n = 1'b1; in_valid = 1'b0; in_instr = '0; out_ready = 1'b1;
        wb_en = 1'b0; wb_addr = '0; wb_data = '0;
        m_clear();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        outs = {out_valid, aluop, is_alu_op, illegal, rd, val1, val2};
        if (outs !== 80'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Writeback R1=8, R2=8, then ADD r3,r1,r2
        cyc(1'b0, 32'd0, 1'b1, 1'b1, 4'd1, 32'd8, iss);
        cyc(1'b0, 32'd0, 1'b1, 1'b1, 4'd2, 32'd8, iss);
        cyc(1'b1, mk(5'd4, 4'd3, 4'd1, 1'b0, 4'd2, 16'd0), 1'b1, 1'b0, 4'd0, 32'd0, iss);
        // SUB r4,r3,r1 stalls on r3, then issues in the writeback cycle of r3
        cyc(1'b1, mk(5'd5, 4'd4, 4'd3, 1'b0, 4'd1, 16'd0), 1'b1, 1'b0, 4'd0, 32'd0, iss);
        cyc(1'b1, mk(5'd5, 4'd4, 4'd3, 1'b0, 4'd1, 16'd0), 1'b1, 1'b1, 4'd3, 32'h10, iss);
        // MOVL r5 (use_imm set) and MOVH r5 (use_imm clear) with R5 = 0xABCD0000
        cyc(1'b0, 32'd0, 1'b1, 1'b1, 4'd5, 32'hABCD_0000, iss);
        cyc(1'b1, mk(5'd2, 4'd5, 4'd0, 1'b1, 4'd0, 16'h1234), 1'b1, 1'b0, 4'd0, 32'd0, iss);
        cyc(1'b1, {5'd3, 4'd5, 4'd0, 1'b0, 2'b00, 16'h5678}, 1'b1, 1'b1, 4'd5, 32'hABCD_0000, iss);
        // Undefined opcode with rd=6 must not mark r6 busy
        cyc(1'b1, mk(5'h1F, 4'd6, 4'd1, 1'b0, 4'd2, 16'd0), 1'b1, 1'b0, 4'd0, 32'd0, iss);
        cyc(1'b1, mk(5'd4, 4'd7, 4'd6, 1'b0, 4'd6, 16'd0), 1'b1, 1'b0, 4'd0, 32'd0, iss);
        cyc(1'b0, 32'd0, 1'b1, 1'b0, 4'd0, 32'd0, iss);
        // Backpressure: hold for three cycles, then full-rate drain
        a_op = mk(5'd4, 4'd8, 4'd1, 1'b0, 4'd2, 16'd0);
        b_op = mk(5'd5, 4'd9, 4'd2, 1'b0, 4'd1, 16'd0);
        c_op = mk(5'd11, 4'd10, 4'd1, 1'b0, 4'd0, 16'd0);
        cyc(1'b1, a_op, 1'b0, 1'b0, 4'd0, 32'd0, iss);
        for (int i = 0; i < 3; i++) cyc(1'b1, b_op, 1'b0, 1'b0, 4'd0, 32'd0, iss);
        cyc(1'b1, b_op, 1'b1, 1'b0, 4'd0, 32'd0, iss);
        cyc(1'b1, c_op, 1'b1, 1'b0, 4'd0, 32'd0, iss);
        cyc(1'b0, 32'd0, 1'b1, 1'b0, 4'd0, 32'd0, iss);
        // Reset while an output is held and the next instruction stalls on busy r4
        cyc(1'b1, mk(5'd4, 4'd12, 4'd1, 1'b0, 4'd2, 16'd0), 1'b0, 1'b0, 4'd0, 32'd0, iss);
        cyc(1'b1, mk(5'd4, 4'd11, 4'd4, 1'b0, 4'd1, 16'd0), 1'b0, 1'b0, 4'd0, 32'd0, iss);
        #3 rst_n = 1'b0;
        #1;
        checks++;
        outs = {out_valid, aluop, is_alu_op, illegal, rd, val1, val2};
        if (outs !== 80'd0) begin
            errors++;
            $display("FAIL async_reset: got %h expected 0", outs);
        end
        m_clear();
        in_valid = 1'b0; wb_en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        // r4 no longer busy, R1 reads zero
        cyc(1'b1, mk(5'd4, 4'd6, 4'd1, 1'b0, 4'd4, 16'd0), 1'b1, 1'b0, 4'd0, 32'd0, iss);
        cyc(1'b0, 32'd0, 1'b1, 1'b0, 4'd0, 32'd0, iss);

        // Random traffic; an unaccepted instruction is held until it issues
        have = 1'b0;
        ins = 32'd0;
        for (int n = 0; n < 1500; n++) begin
            if (!have) begin
                ins = $urandom;
                if ($urandom_range(0, 7) == 0) op = 5'($urandom_range(0, 31));
                else                           op = legal_ops[$urandom_range(0, 13)];
                ins[31:27] = op;
                have = 1'b1;
            end
            cyc(1'($urandom_range(0, 3) != 0), ins, 1'($urandom_range(0, 3) != 0),
                1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom, iss);
            if (iss) have = 1'b0;
        end

        for (int i = 0; i < 4; i++) cyc(1'b0, 32'd0, 1'b1, 1'b0, 4'd0, 32'd0, iss);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d outputs still pending, expected 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- ID stage of the PikaRISC core; sits directly upstream of alu.
- Accepts a fetched 32-bit instruction over a valid/ready handshake and decodes it into aluop/is_alu_op.
- Reads operands from an internal 16x32 register file with writeback bypass, and tracks pending destinations in a scoreboard.
- Presents val1/val2/aluop/is_alu_op/rd in an output pipeline register.

Parameters:
- DATA_W, 32, operand/register width.
- NREG, 16, register count; fixed by the 4-bit register fields.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction valid.
- in_ready  out  1  stage can accept the instruction this cycle.
- in_instr  in  32  instruction word.
- out_valid  out  1  output register holds a decoded op.
- out_ready  in  1  downstream (alu/EX) accepts the op.
- aluop  out  5  ALUOP_* code to alu.
- is_alu_op  out  1  op is a legal ALU op.
- val1  out  DATA_W  first operand.
- val2  out  DATA_W  second operand.
- rd  out  4  destination register.
- illegal  out  1  undefined opcode (pulse-qualified by out_valid).
- wb_en  in  1  writeback strobe.
- wb_addr  in  4  writeback register.
- wb_data  in  DATA_W  writeback value.

Behaviour:
- Encoding:
  - [31:27] op = ALUOP_* value; [26:23] rd; [22:19] rs1; [18] use_imm.
  - [17:14] rs2 when use_imm=0; [15:0] imm16 when use_imm=1.
- Legal ops: MOV 0, MOVL 2, MOVH 3, ADD 4, SUB 5, MUL 6, DIV 7, AND 8, OR 9, NOT A, XOR B, SHL C, SHR D, ASR E.
  - Other codes: is_alu_op=0, illegal=1, rd forced 0, no scoreboard set; the op still passes downstream.
- Operands:
  - val1 = R[rs1]; val2 = use_imm ? zero-extended imm16 : R[rs2].
  - MOVL/MOVH always use imm16 regardless of use_imm, and take val1 = R[rd] (the ALU merges halves).
- R0 reads 0; writes to R0 are ignored; R0 is never marked busy.
- Register file: synchronous write on wb_en. A same-cycle read of wb_addr returns wb_data (bypass).
- Scoreboard: 16 busy bits.
  - Issue (in_valid && in_ready, legal op, rd!=0) sets busy[rd].
  - wb_en clears busy[wb_addr].
  - Same cycle, same register: set wins.
- Stall: a source register (rs1, rs2 if used, rd for MOVL/MOVH) is busy and not being cleared by wb this cycle.
- in_ready = !stall && (!out_valid || out_ready).
- Handshake and latency:
  - 1-cycle latency; the output register loads on in_valid && in_ready.
  - out_valid drops when out_ready is high and nothing is loaded.
  - Outputs hold stable while out_valid && !out_ready.
  - Full throughput with no hazards.
- Reset (async, rst_n low):
  - out_valid=0, aluop=0, is_alu_op=0, val1=0, val2=0, rd=0, illegal=0.
  - All busy bits cleared; all registers 0.
  - Reset mid-stall discards the held instruction; the upstream stage must re-present it.
- in_instr ignored when in_valid=0; no state change.

Decomposition:
- Shared package/defines: ALUOP_* codes (existing defines.v), field bit positions, NREG, REG_ADDR_W=4.
- One sub-module: regfile_bypass (16x32, 2 read ports, 1 write port, R0 zero, write-through bypass).
- Scoreboard and decode stay in decode_stage.

Test Plan:
- Reset, then wb R1=8, R2=8; issue ADD r3,r1,r2 (use_imm=0) -> next cycle out_valid=1, aluop=4, val1=8, val2=8, rd=3, is_alu_op=1; busy[3]=1.
- Issue SUB r4,r3,r1 while busy[3] set -> in_ready=0. Assert wb_en, wb_addr=3, wb_data=0x10 -> same-cycle accept, val1=0x10, val2=8.
- MOVL r5,imm=0x1234 with R5=0xABCD0000 -> aluop=2, val1=0xABCD0000, val2=0x00001234; MOVH same.
- op=0x1F -> is_alu_op=0, illegal=1, rd=0, scoreboard unchanged.
- Back-to-back independent ops with out_ready=0 for 3 cycles -> outputs stable, in_ready=0. Release -> one op per cycle, no loss or duplication.
- Assert rst_n=0 mid-stall -> out_valid=0 and all busy bits 0 immediately (async). Read of R1 after reset = 0.
